// File: rtl/legv8_data_memory_ts.sv
// legv8_data_memory_ts: byte-addressable data memory responding on the LEGv8
// tri-state memory bus. Supports byte/half/word/double accesses, little-endian,
// wrap-around addressing and a programmable number of wait states (0..15).
// Optional build macro MEM_ALIGN_FAULT_EN adds a mem_fault output that flags
// misaligned accesses; such stores are suppressed and such loads return zero.
// ADDR_BITS must be at least 3 so that a double-word offset fits in the window.
module legv8_data_memory_ts #(
  parameter int          ADDR_BITS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  inout  wire  [63:0] data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  output logic        mem_ready,
  output logic        mem_busy
`ifdef MEM_ALIGN_FAULT_EN
  ,
  output logic        mem_fault
`endif
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size, starting at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

`ifdef MEM_ALIGN_FAULT_EN
  // An access is misaligned when the offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] low, input logic [1:0] sz);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = low[0];
      2'b10:   r = |low[1:0];
      2'b11:   r = |low;
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  logic [7:0]           mem [DEPTH];
  state_t               state;
  state_t               state_next;
  logic [3:0]           cnt;
  logic [3:0]           cnt_next;
  logic                 type_write;
  logic                 type_write_next;
  logic                 sel;
  logic                 req;
  logic [ADDR_BITS-1:0] offset;
  logic [7:0]           byte_en;
  logic                 commit_write;
  logic                 drive_load;
  logic [63:0]          load_data;
`ifdef MEM_ALIGN_FAULT_EN
  logic                 misaligned;
`endif

  assign sel     = (address[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign req     = sel & (mem_read | mem_write);
  assign offset  = address[ADDR_BITS-1:0];
  assign byte_en = size_mask(size);

`ifdef MEM_ALIGN_FAULT_EN
  assign misaligned = is_misaligned(offset[2:0], size);
`endif

  // State register, wait counter and the request type captured on entry to WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      type_write <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      type_write <= type_write_next;
    end
  end

  // Next-state logic: count down wait states, abort if the request drops or changes type.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    type_write_next = type_write;
    case (state)
      ST_IDLE: begin
        if (req && HAS_WAIT) begin
          state_next      = ST_WAIT;
          cnt_next        = WAIT_LOAD;
          type_write_next = mem_write;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req || (mem_write != type_write)) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Completion: combinational single-cycle access without wait states, else one DONE cycle.
  always_comb begin
    mem_ready = 1'b0;
    if (reset) begin
      mem_ready = 1'b0;
    end else if (HAS_WAIT) begin
      mem_ready = (state == ST_DONE) & req;
    end else begin
      mem_ready = req;
    end
  end

  assign mem_busy = (state == ST_WAIT);

`ifdef MEM_ALIGN_FAULT_EN
  assign mem_fault    = mem_ready & misaligned;
  assign commit_write = mem_ready & mem_write & ~misaligned;
`else
  assign commit_write = mem_ready & mem_write;
`endif

  // Write priority: with both strobes high the bus is never driven by memory.
  assign drive_load = mem_ready & mem_read & ~mem_write;

  // Little-endian assembly of the addressed bytes, zero-extended, wrapping at the top.
  always_comb begin
    load_data = 64'h0;
    for (int k = 0; k < 8; k++) begin
      if (byte_en[k]) begin
        load_data[8*k +: 8] = mem[offset + ADDR_BITS'(k)];
      end else begin
        load_data[8*k +: 8] = 8'h00;
      end
    end
`ifdef MEM_ALIGN_FAULT_EN
    if (misaligned) begin
      load_data = 64'h0;
    end else begin
      load_data = load_data;
    end
`endif
  end

  assign data = drive_load ? load_data : {64{1'bz}};

  // Byte-lane store at the completing edge; the array itself is never reset.
  always_ff @(posedge clock) begin
    if (commit_write) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_en[k]) begin
          mem[offset + ADDR_BITS'(k)] <= data[8*k +: 8];
        end
      end
    end
  end

endmodule
